// File: rtl/lottery_input_ctrl.sv
// Input front end for the lottery game: synchronizes and debounces the two pushbuttons,
// validates the digit switches and sequences five digits followed by a finish press.
module lottery_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_insert_n,
    input  logic       key_finish_n,
    input  logic [3:0] sw_num,
    output logic       insert,
    output logic [3:0] num,
    output logic       finish,
    output logic [2:0] digit_count,
    output logic       ready,
    output logic       err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        WAIT_FIN = 2'd1,
        DONE     = 2'd2
    } state_t;

    // Key vectors: bit 0 = insert key, bit 1 = finish key (active-low levels).
    logic [1:0]       key_s1_q;
    logic [1:0]       key_s2_q;
    logic [3:0]       sw_s1_q;
    logic [3:0]       sw_s2_q;
    logic [1:0]       db_q;
    logic [1:0]       press_q;
    logic [CNT_W-1:0] cnt_q [2];

    state_t           state_q;
    logic             insert_q;
    logic             finish_q;
    logic             err_q;
    logic             ready_q;
    logic [3:0]       num_q;
    logic [2:0]       digit_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1_q <= 2'b11;
            key_s2_q <= 2'b11;
            sw_s1_q  <= 4'd0;
            sw_s2_q  <= 4'd0;
        end else begin
            key_s1_q <= {key_finish_n, key_insert_n};
            key_s2_q <= key_s1_q;
            sw_s1_q  <= sw_num;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // press_q fires for one cycle when the debounced level falls; a rise never does.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_q    <= 2'b11;
            press_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                press_q[i] <= 1'b0;
                if (key_s2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i]   <= '0;
                    db_q[i]    <= key_s2_q[i];
                    press_q[i] <= ~key_s2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= COLLECT;
            insert_q      <= 1'b0;
            finish_q      <= 1'b0;
            err_q         <= 1'b0;
            ready_q       <= 1'b0;
            num_q         <= 4'd0;
            digit_count_q <= 3'd0;
        end else begin
            insert_q <= 1'b0;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (press_q[0]) begin
                        if (sw_s2_q <= 4'd9 && digit_count_q < 3'd5) begin
                            insert_q      <= 1'b1;
                            num_q         <= sw_s2_q;
                            digit_count_q <= digit_count_q + 3'd1;
                            if (digit_count_q == 3'd4) begin
                                state_q <= WAIT_FIN;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    // A finish press before all digits are in is a user error.
                    if (press_q[1]) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT_FIN: begin
                    if (press_q[1]) begin
                        finish_q <= 1'b1;
                        state_q  <= DONE;
                        ready_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= COLLECT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign insert      = insert_q;
    assign finish      = finish_q;
    assign err         = err_q;
    assign ready       = ready_q;
    assign num         = num_q;
    assign digit_count = digit_count_q;

endmodule

// File: tb/tb_lottery_input_ctrl.sv
// Directed bench for lottery_input_ctrl with DEBOUNCE_CYCLES=4; pulses are tallied by a
// negedge monitor and compared against hand-computed expectations.
module tb_lottery_input_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_insert_n = 1'b1;
    logic       key_finish_n = 1'b1;
    logic [3:0] sw_num = 4'd0;
    logic       insert;
    logic [3:0] num;
    logic       finish;
    logic [2:0] digit_count;
    logic       ready;
    logic       err;

    int total = 0;
    int fails = 0;
    int ins_cnt = 0;
    int fin_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int num_log [32];
    int i0, f0, e0;

    lottery_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_insert_n (key_insert_n),
        .key_finish_n (key_finish_n),
        .sw_num       (sw_num),
        .insert       (insert),
        .num          (num),
        .finish       (finish),
        .digit_count  (digit_count),
        .ready        (ready),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (insert) begin
            if (ins_cnt < 32) num_log[ins_cnt] = int'(num);
            ins_cnt = ins_cnt + 1;
        end
        if (finish) fin_cnt = fin_cnt + 1;
        if (err) err_cnt = err_cnt + 1;
        if (insert && finish) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk) reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    // Clean press: hold the selected keys low long enough to debounce, then release.
    task automatic press(input bit ins, input bit fin, input logic [3:0] val);
        @(negedge clk);
        sw_num = val;
        repeat (3) @(negedge clk);
        key_insert_n = ~ins;
        key_finish_n = ~fin;
        repeat (10) @(negedge clk);
        key_insert_n = 1'b1;
        key_finish_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) num_log[i] = -1;

        do_reset(2);
        chk("rst_insert", int'(insert), 0);
        chk("rst_finish", int'(finish), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_num", int'(num), 0);
        chk("rst_count", int'(digit_count), 0);

        // Exact press-to-pulse latency: pulse visible only after edge k+6.
        sw_num = 4'd5;
        repeat (4) @(negedge clk);
        key_insert_n = 1'b0;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 chk("lat_early", int'(insert), 0);
        @(posedge clk);
        #1 chk("lat_pulse", int'(insert), 1);
        chk("lat_num", int'(num), 5);
        @(posedge clk);
        #1 chk("lat_end", int'(insert), 0);
        @(negedge clk) key_insert_n = 1'b1;
        repeat (10) @(negedge clk);

        // Bouncing key followed by a long hold.
        do_reset(2);
        i0 = ins_cnt; e0 = err_cnt;
        sw_num = 4'd5;
        repeat (3) @(negedge clk);
        key_insert_n = 1'b0; @(negedge clk);
        key_insert_n = 1'b1; @(negedge clk);
        key_insert_n = 1'b0; @(negedge clk);
        key_insert_n = 1'b1; @(negedge clk);
        key_insert_n = 1'b0;
        repeat (10) @(negedge clk);
        key_insert_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("bounce_pulses", ins_cnt - i0, 1);
        chk("bounce_num", int'(num), 5);
        chk("bounce_count", int'(digit_count), 1);
        chk("bounce_err", err_cnt - e0, 0);

        // Full game: five digits, finish, then ignored presses.
        do_reset(2);
        i0 = ins_cnt; e0 = err_cnt; f0 = fin_cnt;
        press(1, 0, 4'd5);
        press(1, 0, 4'd0);
        press(1, 0, 4'd9);
        press(1, 0, 4'd6);
        press(1, 0, 4'd7);
        chk("game_d0", num_log[i0], 5);
        chk("game_d1", num_log[i0+1], 0);
        chk("game_d2", num_log[i0+2], 9);
        chk("game_d3", num_log[i0+3], 6);
        chk("game_d4", num_log[i0+4], 7);
        chk("game_count", int'(digit_count), 5);
        chk("game_ready", int'(ready), 1);
        press(1, 0, 4'd2);
        chk("waitfin_ins_ignored", ins_cnt - i0, 5);
        chk("waitfin_sat", int'(digit_count), 5);
        press(0, 1, 4'd2);
        chk("game_finish", fin_cnt - f0, 1);
        chk("game_ready_off", int'(ready), 0);
        press(1, 0, 4'd3);
        press(0, 1, 4'd3);
        press(1, 1, 4'd3);
        chk("done_ins", ins_cnt - i0, 5);
        chk("done_fin", fin_cnt - f0, 1);
        chk("done_err", err_cnt - e0, 0);

        // Out-of-range digit.
        do_reset(2);
        i0 = ins_cnt; e0 = err_cnt;
        press(1, 0, 4'd12);
        chk("bad_err", err_cnt - e0, 1);
        chk("bad_ins", ins_cnt - i0, 0);
        chk("bad_count", int'(digit_count), 0);

        // Early finish, then simultaneous presses.
        press(1, 0, 4'd1);
        press(1, 0, 4'd2);
        i0 = ins_cnt; e0 = err_cnt; f0 = fin_cnt;
        press(0, 1, 4'd2);
        chk("early_err", err_cnt - e0, 1);
        chk("early_fin", fin_cnt - f0, 0);
        chk("early_count", int'(digit_count), 2);
        press(1, 1, 4'd3);
        chk("both_ins", ins_cnt - i0, 1);
        chk("both_err", err_cnt - e0, 2);
        chk("both_num", int'(num), 3);
        chk("both_count", int'(digit_count), 3);

        // Reset mid-game discards digits.
        do_reset(1);
        press(1, 0, 4'd4);
        chk("rst_mid_count", int'(digit_count), 1);
        chk("rst_mid_num", int'(num), 4);

        // Key held low across reset release counts as a new press.
        @(negedge clk) sw_num = 4'd6;
        repeat (3) @(negedge clk);
        key_insert_n = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        key_insert_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_count", int'(digit_count), 1);
        chk("held_num", int'(num), 6);

        chk("never_both", both_cnt, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
